// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised inter-stage pipeline register:
// state encoding, D->E field indices and default geometry.
package pipe_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned FIELDS_DEF = 6;

   // Field slots of the D->E instance; field k lives at [k*DATA_W +: DATA_W]
   localparam int unsigned F_PC     = 0;
   localparam int unsigned F_V1     = 1;
   localparam int unsigned F_V2     = 2;
   localparam int unsigned F_EXTIMM = 3;
   localparam int unsigned F_SHIFT  = 4;
   localparam int unsigned F_PCADD8 = 5;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FULL    = 2'd1,
      SKIDDED = 2'd2
   } state_e;

   // Number of payload entries held in a given state
   function automatic logic [1:0] occ_of(state_e s);
      logic [1:0] occ;
      occ = 2'd0;
      case (s)
         FULL:    occ = 2'd1;
         SKIDDED: occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned FIELDS     = FIELDS_DEF,
   parameter int unsigned SKID       = 1,
   parameter int unsigned CLEAR_DATA = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [FIELDS*DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [FIELDS*DATA_W-1:0] out_data,
   input  logic                     flush,
   output logic [1:0]               occupancy,
   output logic [CNT_W-1:0]         stall_cnt,
   input  logic                     stall_clr
);

   localparam int unsigned PAY_W = FIELDS * DATA_W;

   state_e           r_state;
   state_e           w_state_nx;
   logic [PAY_W-1:0] r_main;
   logic [PAY_W-1:0] w_main_nx;
   logic [PAY_W-1:0] r_skid;
   logic [PAY_W-1:0] w_skid_nx;
   logic             r_out_valid;
   logic [1:0]       r_occ;
   logic             r_rdy;
   logic             w_in_fire;
   logic             w_stall;

   // r_rdy is 0 in reset and 1 once the block is out of reset and not skidded
   assign in_ready  = (SKID != 0) ? r_rdy : (r_rdy & (out_ready | ~r_out_valid));
   assign w_in_fire = in_valid & in_ready;

   // Next-state and payload steering; flush overrides every transition
   always_comb begin
      w_state_nx = r_state;
      w_main_nx  = r_main;
      w_skid_nx  = r_skid;
      if (flush) begin
         w_state_nx = EMPTY;
         if (CLEAR_DATA != 0) begin
            w_main_nx = '0;
            w_skid_nx = '0;
         end
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_fire) begin
                  w_state_nx = FULL;
                  w_main_nx  = in_data;
               end
            end
            FULL: begin
               if (w_in_fire) begin
                  if (out_ready) begin
                     w_main_nx = in_data;
                  end else if (SKID != 0) begin
                     w_state_nx = SKIDDED;
                     w_skid_nx  = in_data;
                  end
               end else if (out_ready) begin
                  w_state_nx = EMPTY;
               end
            end
            SKIDDED: begin
               if (out_ready) begin
                  w_state_nx = FULL;
                  w_main_nx  = r_skid;
               end
            end
            default: begin
               w_state_nx = EMPTY;
            end
         endcase
      end
   end

   // Status outputs are registered copies decoded from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= EMPTY;
         r_main      <= '0;
         r_skid      <= '0;
         r_out_valid <= 1'b0;
         r_occ       <= 2'd0;
         r_rdy       <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_main      <= w_main_nx;
         r_skid      <= w_skid_nx;
         r_out_valid <= (w_state_nx != EMPTY);
         r_occ       <= occ_of(w_state_nx);
         r_rdy       <= (w_state_nx != SKIDDED);
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_main;
   assign occupancy = r_occ;

   assign w_stall = r_out_valid & ~out_ready;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (reset),
      .i_inc (w_stall),
      .i_clr (stall_clr),
      .o_cnt (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg (SKID=1 and SKID=0 instances).
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned NF = 6;
   localparam int unsigned PW = DW * NF;
   localparam int unsigned CW = 4;

   logic          clk;
   logic          reset;

   logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_stall_clr;
   logic [PW-1:0] a_in_data, a_out_data;
   logic [1:0]    a_occ;
   logic [CW-1:0] a_cnt;

   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_stall_clr;
   logic [PW-1:0] b_in_data, b_out_data;
   logic [1:0]    b_occ;
   logic [CW-1:0] b_cnt;

   int n_tests;
   int n_fail;

   typedef struct {
      logic        in_valid;
      logic        out_ready;
      logic        flush;
      logic [31:0] val;
      logic        exp_valid;
      logic [31:0] exp_val;
      logic [1:0]  exp_occ;
      logic        exp_rdy;
   } vec_t;

   vec_t vecs[12];

   pipe_stage_reg #(.DATA_W(DW), .FIELDS(NF), .SKID(1), .CLEAR_DATA(1), .CNT_W(CW)) dut_a (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .flush(a_flush), .occupancy(a_occ), .stall_cnt(a_cnt), .stall_clr(a_stall_clr)
   );

   pipe_stage_reg #(.DATA_W(DW), .FIELDS(NF), .SKID(0), .CLEAR_DATA(1), .CNT_W(CW)) dut_b (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .flush(b_flush), .occupancy(b_occ), .stall_cnt(b_cnt), .stall_clr(b_stall_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Distinct per-field pattern; mk(0) is all zeros
   function automatic logic [PW-1:0] mk(logic [31:0] v);
      logic [PW-1:0] r;
      r = '0;
      for (int k = 0; k < int'(NF); k++) r[k*DW +: DW] = v * 32'(k + 1);
      return r;
   endfunction

   function automatic vec_t mkv(logic iv, logic ordy, logic fl, logic [31:0] v,
                                logic ev, logic [31:0] ed, logic [1:0] eo, logic er);
      vec_t t;
      t.in_valid = iv; t.out_ready = ordy; t.flush = fl; t.val = v;
      t.exp_valid = ev; t.exp_val = ed; t.exp_occ = eo; t.exp_rdy = er;
      return t;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b0;
      a_in_valid = 0; a_out_ready = 0; a_flush = 0; a_stall_clr = 0; a_in_data = '0;
      b_in_valid = 0; b_out_ready = 0; b_flush = 0; b_stall_clr = 0; b_in_data = '0;

      //              iv ordy fl  val        ev  exp        occ  rdy
      vecs[0]  = mkv(0, 1, 0, 32'h0,      0, 32'h0,      2'd0, 1);
      vecs[1]  = mkv(1, 1, 0, 32'h100,    1, 32'h100,    2'd1, 1);
      vecs[2]  = mkv(1, 1, 0, 32'h104,    1, 32'h104,    2'd1, 1);
      vecs[3]  = mkv(1, 1, 0, 32'h108,    1, 32'h108,    2'd1, 1);
      vecs[4]  = mkv(0, 1, 0, 32'h0,      0, 32'h108,    2'd0, 1);
      vecs[5]  = mkv(1, 0, 0, 32'hA0,     1, 32'hA0,     2'd1, 1);
      vecs[6]  = mkv(1, 0, 0, 32'hB0,     1, 32'hA0,     2'd2, 0);
      vecs[7]  = mkv(1, 0, 0, 32'hB0,     1, 32'hA0,     2'd2, 0);
      vecs[8]  = mkv(0, 1, 0, 32'h0,      1, 32'hB0,     2'd1, 1);
      vecs[9]  = mkv(0, 1, 0, 32'h0,      0, 32'hB0,     2'd0, 1);
      vecs[10] = mkv(1, 0, 0, 32'h55,     1, 32'h55,     2'd1, 1);
      vecs[11] = mkv(1, 0, 1, 32'hDEAD,   0, 32'h0,      2'd0, 1);

      repeat (3) @(posedge clk);
      #2;
      chk("rst.a_in_ready",  256'(a_in_ready),  256'(0));
      chk("rst.a_out_valid", 256'(a_out_valid), 256'(0));
      chk("rst.a_out_data",  256'(a_out_data),  256'(0));
      chk("rst.a_occ",       256'(a_occ),       256'(0));
      chk("rst.a_cnt",       256'(a_cnt),       256'(0));
      chk("rst.b_in_ready",  256'(b_in_ready),  256'(0));
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         a_in_valid  = vecs[i].in_valid;
         a_out_ready = vecs[i].out_ready;
         a_flush     = vecs[i].flush;
         a_in_data   = mk(vecs[i].val);
         tick();
         chk($sformatf("v%0d.out_valid", i), 256'(a_out_valid), 256'(vecs[i].exp_valid));
         chk($sformatf("v%0d.out_data", i),  256'(a_out_data),  256'(mk(vecs[i].exp_val)));
         chk($sformatf("v%0d.occ", i),       256'(a_occ),       256'(vecs[i].exp_occ));
         chk($sformatf("v%0d.in_ready", i),  256'(a_in_ready),  256'(vecs[i].exp_rdy));
      end

      // After the flush, nothing of the squashed payload may surface
      a_in_valid = 0; a_out_ready = 1; a_flush = 0; a_in_data = '0;
      tick();
      chk("flush.out_valid", 256'(a_out_valid), 256'(0));
      chk("flush.out_data",  256'(a_out_data),  256'(0));
      chk("flush.occ",       256'(a_occ),       256'(0));

      // Stall counter saturation and clear priority
      a_stall_clr = 1;
      tick();
      chk("cnt.clr0", 256'(a_cnt), 256'(0));
      a_stall_clr = 0; a_in_valid = 1; a_out_ready = 0; a_in_data = mk(32'h77);
      tick();
      a_in_valid = 0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n == 3) chk("cnt.three", 256'(a_cnt), 256'(3));
      end
      chk("cnt.sat", 256'(a_cnt), 256'(15));
      a_stall_clr = 1;
      tick();
      chk("cnt.clr_wins", 256'(a_cnt), 256'(0));
      a_stall_clr = 0;
      tick();
      chk("cnt.resume", 256'(a_cnt), 256'(1));
      a_out_ready = 1;
      tick();
      chk("cnt.drain_valid", 256'(a_out_valid), 256'(0));

      // Async reset while skidded
      a_in_valid = 1; a_out_ready = 0; a_in_data = mk(32'h11);
      tick();
      a_in_data = mk(32'h22);
      tick();
      chk("ar.pre_occ", 256'(a_occ), 256'(2));
      a_in_valid = 0;
      #1 reset = 1'b0;
      #1;
      chk("ar.out_valid", 256'(a_out_valid), 256'(0));
      chk("ar.in_ready",  256'(a_in_ready),  256'(0));
      chk("ar.occ",       256'(a_occ),       256'(0));
      chk("ar.out_data",  256'(a_out_data),  256'(0));
      chk("ar.cnt",       256'(a_cnt),       256'(0));
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("ar.rel_ready", 256'(a_in_ready), 256'(1));
      chk("ar.rel_occ",   256'(a_occ),      256'(0));
      a_in_valid = 1; a_out_ready = 1; a_in_data = mk(32'h33);
      tick();
      chk("ar.resume_valid", 256'(a_out_valid), 256'(1));
      chk("ar.resume_data",  256'(a_out_data),  256'(mk(32'h33)));
      a_in_valid = 0;
      tick();

      // SKID=0: combinational in_ready follows out_ready
      b_in_valid = 1; b_out_ready = 0; b_in_data = mk(32'hC0);
      tick();
      chk("b.first_valid", 256'(b_out_valid), 256'(1));
      chk("b.first_data",  256'(b_out_data),  256'(mk(32'hC0)));
      b_in_data = mk(32'hC4);
      #1;
      chk("b.stall_ready", 256'(b_in_ready), 256'(0));
      tick();
      chk("b.held_data", 256'(b_out_data), 256'(mk(32'hC0)));
      chk("b.occ_max",   256'(b_occ),      256'(1));
      b_out_ready = 1;
      #1;
      chk("b.pass_ready", 256'(b_in_ready), 256'(1));
      tick();
      chk("b.replace_data",  256'(b_out_data),  256'(mk(32'hC4)));
      chk("b.replace_valid", 256'(b_out_valid), 256'(1));
      chk("b.replace_occ",   256'(b_occ),       256'(1));
      b_in_valid = 0;
      tick();
      chk("b.drain_valid", 256'(b_out_valid), 256'(0));
      chk("b.drain_occ",   256'(b_occ),       256'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
